// File: rtl/branch_pkg.sv
// Shared types and constants for the branch redirect controller.
package branch_pkg;

    localparam int unsigned PC_W       = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [0:0] {
        StIdle,
        StRedirect
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
        logic            mispred;
    } bpu_upd_t;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Bus between EX branch resolution, fetch redirect and predictor update.
// master: controller side; slave: pipeline/predictor side.
interface branch_redirect_ctrl_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
);

    logic            ex_valid;
    logic            ex_stall;
    logic            ex_is_branch;
    logic            ex_taken;
    logic [PC_W-1:0] ex_pc;
    logic [PC_W-1:0] ex_target;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_pred_target;
    logic            if_ready;

    logic             flush_if_id;
    logic             flush_id_ex;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             bpu_upd_valid;
    logic [PC_W-1:0]  bpu_upd_pc;
    logic [PC_W-1:0]  bpu_upd_target;
    logic             bpu_upd_taken;
    logic             bpu_upd_mispred;
    logic [CNT_W-1:0] perf_branch_cnt;
    logic [CNT_W-1:0] perf_mispred_cnt;

    modport master (
        input  ex_valid, ex_stall, ex_is_branch, ex_taken, ex_pc, ex_target,
        input  ex_pred_taken, ex_pred_target, if_ready,
        output flush_if_id, flush_id_ex, redirect_valid, redirect_pc,
        output bpu_upd_valid, bpu_upd_pc, bpu_upd_target, bpu_upd_taken, bpu_upd_mispred,
        output perf_branch_cnt, perf_mispred_cnt
    );

    modport slave (
        output ex_valid, ex_stall, ex_is_branch, ex_taken, ex_pc, ex_target,
        output ex_pred_taken, ex_pred_target, if_ready,
        input  flush_if_id, flush_id_ex, redirect_valid, redirect_pc,
        input  bpu_upd_valid, bpu_upd_pc, bpu_upd_target, bpu_upd_taken, bpu_upd_mispred,
        input  perf_branch_cnt, perf_mispred_cnt
    );

endinterface

// File: rtl/branch_mispred_detect.sv
// Combinational mispredict detection and corrected fetch PC.
module branch_mispred_detect #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned INST_BYTES = 4
) (
    input  logic            ex_taken_i,
    input  logic [PC_W-1:0] ex_pc_i,
    input  logic [PC_W-1:0] ex_target_i,
    input  logic            ex_pred_taken_i,
    input  logic [PC_W-1:0] ex_pred_target_i,
    output logic            mispred_o,
    output logic [PC_W-1:0] fix_pc_o
);

    always_comb begin
        mispred_o = (ex_taken_i != ex_pred_taken_i) ||
                    (ex_taken_i && ex_pred_taken_i && (ex_target_i != ex_pred_target_i));
        // Fall-through wraps modulo 2^PC_W.
        fix_pc_o  = ex_taken_i ? ex_target_i : ex_pc_i + PC_W'(INST_BYTES);
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencing after EX branch resolution.
// Optional perf counters enabled by BRANCH_PERF_CNT_EN.
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned PC_W       = branch_pkg::PC_W,
    parameter int unsigned INST_BYTES = branch_pkg::INST_BYTES,
    parameter int unsigned CNT_W      = 32
) (
    input logic                    clk,
    input logic                    rst,
    branch_redirect_ctrl_if.master bus
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    bpu_upd_t        upd_q, upd_d;
    logic            upd_valid_q, upd_valid_d;
    logic            fire, mispred, flush;
    logic [PC_W-1:0] fix_pc;

    branch_mispred_detect #(
        .PC_W       (PC_W),
        .INST_BYTES (INST_BYTES)
    ) u_detect (
        .ex_taken_i       (bus.ex_taken),
        .ex_pc_i          (bus.ex_pc),
        .ex_target_i      (bus.ex_target),
        .ex_pred_taken_i  (bus.ex_pred_taken),
        .ex_pred_target_i (bus.ex_pred_target),
        .mispred_o        (mispred),
        .fix_pc_o         (fix_pc)
    );

    // Resolutions seen while redirecting are wrong-path and never fire.
    assign fire = bus.ex_valid & ~bus.ex_stall & bus.ex_is_branch & (state_q == StIdle);

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        flush         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fire && mispred) begin
                    state_d       = StRedirect;
                    redirect_pc_d = fix_pc;
                    flush         = 1'b1;
                end
            end
            StRedirect: begin
                flush = 1'b1;
                if (bus.if_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        upd_valid_d = fire;
        upd_d       = upd_q;
        if (fire) begin
            upd_d.pc      = bus.ex_pc;
            upd_d.target  = bus.ex_target;
            upd_d.taken   = bus.ex_taken;
            upd_d.mispred = mispred;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            redirect_pc_q <= '0;
            upd_q         <= '0;
            upd_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            upd_q         <= upd_d;
            upd_valid_q   <= upd_valid_d;
        end
    end

    // Flushes are combinational, so mask them while reset is held.
    assign bus.flush_if_id     = flush & ~rst;
    assign bus.flush_id_ex     = flush & ~rst;
    assign bus.redirect_valid  = (state_q == StRedirect);
    assign bus.redirect_pc     = redirect_pc_q;
    assign bus.bpu_upd_valid   = upd_valid_q;
    assign bus.bpu_upd_pc      = upd_q.pc;
    assign bus.bpu_upd_target  = upd_q.target;
    assign bus.bpu_upd_taken   = upd_q.taken;
    assign bus.bpu_upd_mispred = upd_q.mispred;

`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (fire && !(&br_cnt_q)) br_cnt_d = br_cnt_q + 1'b1;
        if (fire && mispred && !(&mp_cnt_q)) mp_cnt_d = mp_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign bus.perf_branch_cnt  = br_cnt_q;
    assign bus.perf_mispred_cnt = mp_cnt_q;
`else
    assign bus.perf_branch_cnt  = '0;
    assign bus.perf_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl; a second CNT_W=4 instance
// mirrors the same stimulus to exercise counter saturation.
module tb_branch_redirect_ctrl;

`ifdef BRANCH_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    branch_redirect_ctrl_if #(.PC_W(32), .CNT_W(32)) bus ();
    branch_redirect_ctrl_if #(.PC_W(32), .CNT_W(4))  bus_s ();

    branch_redirect_ctrl #(.PC_W(32), .INST_BYTES(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    branch_redirect_ctrl #(.PC_W(32), .INST_BYTES(4), .CNT_W(4)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    assign bus_s.ex_valid       = bus.ex_valid;
    assign bus_s.ex_stall       = bus.ex_stall;
    assign bus_s.ex_is_branch   = bus.ex_is_branch;
    assign bus_s.ex_taken       = bus.ex_taken;
    assign bus_s.ex_pc          = bus.ex_pc;
    assign bus_s.ex_target      = bus.ex_target;
    assign bus_s.ex_pred_taken  = bus.ex_pred_taken;
    assign bus_s.ex_pred_target = bus.ex_pred_target;
    assign bus_s.if_ready       = bus.if_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                          input logic ptaken, input logic [31:0] ptarget);
        bus.ex_valid       = 1'b1;
        bus.ex_is_branch   = 1'b1;
        bus.ex_pc          = pc;
        bus.ex_taken       = taken;
        bus.ex_target      = target;
        bus.ex_pred_taken  = ptaken;
        bus.ex_pred_target = ptarget;
    endtask

    task automatic run_br(input logic [31:0] pc, input logic taken, input logic ptaken);
        set_br(pc, taken, pc + 32'h100, ptaken, pc + 32'h100);
        step();
        bus.ex_valid = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus.ex_valid = 1'b0;
        bus.ex_stall = 1'b0;
        bus.ex_is_branch = 1'b0;
        bus.ex_taken = 1'b0;
        bus.ex_pc = '0;
        bus.ex_target = '0;
        bus.ex_pred_taken = 1'b0;
        bus.ex_pred_target = '0;
        bus.if_ready = 1'b0;
        step();
        step();

        // Reset state
        check_val("rst_rv", bus.redirect_valid, 0);
        check_val("rst_flush", bus.flush_if_id, 0);
        check_val("rst_rpc", bus.redirect_pc, 0);
        check_val("rst_upd_v", bus.bpu_upd_valid, 0);
        check_val("rst_upd_pc", bus.bpu_upd_pc, 0);
        check_val("rst_brcnt", bus.perf_branch_cnt, 0);
        rst = 1'b0;
        step();

        // Correct prediction
        set_br(32'h1000, 1'b1, 32'h2000, 1'b1, 32'h2000);
        #1;
        check_val("ok_flush", bus.flush_if_id, 0);
        step();
        bus.ex_valid = 1'b0;
        #1;
        check_val("ok_rv", bus.redirect_valid, 0);
        check_val("ok_upd_v", bus.bpu_upd_valid, 1);
        check_val("ok_upd_mp", bus.bpu_upd_mispred, 0);
        check_val("ok_upd_pc", bus.bpu_upd_pc, 32'h1000);
        check_val("ok_upd_tgt", bus.bpu_upd_target, 32'h2000);
        check_val("ok_upd_tk", bus.bpu_upd_taken, 1);
        step();
        check_val("ok_upd_pulse", bus.bpu_upd_valid, 0);
        check_val("ok_upd_hold", bus.bpu_upd_pc, 32'h1000);

        // Direction mispredict, fetch ready immediately
        bus.if_ready = 1'b1;
        set_br(32'h1000, 1'b0, 32'h2000, 1'b1, 32'h2000);
        #1;
        check_val("dir_flush_ifid", bus.flush_if_id, 1);
        check_val("dir_flush_idex", bus.flush_id_ex, 1);
        step();
        bus.ex_valid = 1'b0;
        #1;
        check_val("dir_rv", bus.redirect_valid, 1);
        check_val("dir_rpc", bus.redirect_pc, 32'h1004);
        check_val("dir_flush_t1", bus.flush_if_id, 1);
        check_val("dir_upd_v", bus.bpu_upd_valid, 1);
        check_val("dir_upd_mp", bus.bpu_upd_mispred, 1);
        check_val("dir_upd_tk", bus.bpu_upd_taken, 0);
        step();
        check_val("dir_idle_rv", bus.redirect_valid, 0);
        check_val("dir_idle_flush", bus.flush_id_ex, 0);

        // Target mispredict with fetch backpressure and wrong-path branches
        bus.if_ready = 1'b0;
        set_br(32'h1000, 1'b1, 32'h3000, 1'b1, 32'h2000);
        #1;
        check_val("tgt_flush", bus.flush_if_id, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) set_br(32'h5000, 1'b1, 32'h6000, 1'b0, 32'h0);
            if (i == 3) begin
                bus.if_ready = 1'b1;
                bus.ex_valid = 1'b0;
            end
            #1;
            check_val("tgt_rv", bus.redirect_valid, 1);
            check_val("tgt_rpc", bus.redirect_pc, 32'h3000);
            check_val("tgt_flush_hold", bus.flush_id_ex, 1);
            check_val("tgt_wp_upd_v", bus.bpu_upd_valid, (i == 0) ? 32'd1 : 32'd0);
            check_val("tgt_wp_upd_pc", bus.bpu_upd_pc, 32'h1000);
        end
        step();
        check_val("tgt_done_rv", bus.redirect_valid, 0);
        check_val("tgt_done_flush", bus.flush_if_id, 0);
        check_val("tgt_done_upd_v", bus.bpu_upd_valid, 0);

        // Fall-through wrap-around
        set_br(32'hFFFF_FFFC, 1'b0, 32'h100, 1'b1, 32'h100);
        step();
        bus.ex_valid = 1'b0;
        #1;
        check_val("wrap_rv", bus.redirect_valid, 1);
        check_val("wrap_rpc", bus.redirect_pc, 32'h0);
        step();

        // Non-branch never fires
        set_br(32'h7000, 1'b0, 32'h100, 1'b1, 32'h100);
        bus.ex_is_branch = 1'b0;
        #1;
        check_val("nobr_flush", bus.flush_if_id, 0);
        step();
        bus.ex_valid = 1'b0;
        #1;
        check_val("nobr_upd_v", bus.bpu_upd_valid, 0);

        // Stall holds off a mispredicting branch, then reset mid-redirect
        set_br(32'h4000, 1'b1, 32'h4400, 1'b0, 32'h0);
        bus.ex_stall = 1'b1;
        bus.if_ready = 1'b0;
        #1;
        check_val("stall_flush", bus.flush_if_id, 0);
        step();
        check_val("stall_upd_v", bus.bpu_upd_valid, 0);
        check_val("stall_rv", bus.redirect_valid, 0);
        bus.ex_stall = 1'b0;
        #1;
        check_val("unstall_flush", bus.flush_if_id, 1);
        step();
        bus.ex_valid = 1'b0;
        #1;
        check_val("unstall_rv", bus.redirect_valid, 1);
        check_val("unstall_rpc", bus.redirect_pc, 32'h4400);
        check_val("unstall_upd_pc", bus.bpu_upd_pc, 32'h4000);
        #1;
        rst = 1'b1;
        #1;
        check_val("midrst_rv", bus.redirect_valid, 0);
        check_val("midrst_flush", bus.flush_if_id, 0);
        check_val("midrst_rpc", bus.redirect_pc, 0);
        check_val("midrst_upd_v", bus.bpu_upd_valid, 0);
        step();
        rst = 1'b0;
        bus.if_ready = 1'b1;
        step();
        check_val("postrst_rv", bus.redirect_valid, 0);

        // Perf counters: 5 branches, 2 mispredicts; then 15 more correct ones
        run_br(32'h8000, 1'b1, 1'b1);
        run_br(32'h8010, 1'b0, 1'b1);
        run_br(32'h8020, 1'b0, 1'b0);
        run_br(32'h8030, 1'b1, 1'b0);
        run_br(32'h8040, 1'b1, 1'b1);
        check_val("cnt_br5", bus.perf_branch_cnt, Perf ? 32'd5 : 32'd0);
        check_val("cnt_mp2", bus.perf_mispred_cnt, Perf ? 32'd2 : 32'd0);
        check_val("cnt4_br5", {28'h0, bus_s.perf_branch_cnt}, Perf ? 32'd5 : 32'd0);
        for (int i = 0; i < 15; i++) run_br(32'h9000 + 32'(i * 16), 1'b0, 1'b0);
        check_val("cnt_br20", bus.perf_branch_cnt, Perf ? 32'd20 : 32'd0);
        check_val("cnt_mp_keep", bus.perf_mispred_cnt, Perf ? 32'd2 : 32'd0);
        check_val("cnt4_sat", {28'h0, bus_s.perf_branch_cnt}, Perf ? 32'd15 : 32'd0);
        check_val("cnt4_mp2", {28'h0, bus_s.perf_mispred_cnt}, Perf ? 32'd2 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
